// File: rtl/lease_table_loader_pkg.sv
// Shared lease loader definitions: table geometry, config
// register indices and the loader FSM state encoding.
package lease_table_loader_pkg;

    // LLT entries per table
    localparam int N_ENTRIES     = 128;
    localparam int BW_ENTRIES    = $clog2(N_ENTRIES);
    // write address space covers config indices and both tables
    localparam int BW_ADDR_SPACE = BW_ENTRIES + 1;
    // entry counter holds 0..N_ENTRIES inclusive
    localparam int BW_CNT        = BW_ENTRIES + 1;

    // config register index, in image order after the count word
    typedef enum logic [2:0] {
        CON_DEFAULT_LEASE  = 3'd0,
        CON_LEASE1         = 3'd1,
        CON_DUAL_PROB      = 3'd2,
        CON_REFS_PER_PHASE = 3'd3,
        CON_DUAL_LEASE_REF = 3'd4
    } con_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_CFG,
        ST_ADDR,
        ST_LEASE,
        ST_CLEAR,
        ST_FIN
    } state_t;

endpackage

// File: rtl/lease_loader_fetch.sv
// Single-outstanding req/ack word fetcher.
// Ports: load_i/base_i start at a base word, next_i fetches the
// following word; word_o/valid_o present data the cycle after ack.
module lease_loader_fetch (
    input  logic        clock_i,
    input  logic        resetn_i,
    input  logic        load_i,
    input  logic        next_i,
    input  logic [31:0] base_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] word_o,
    output logic        valid_o
);

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
            word_o     <= '0;
            valid_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (load_i) begin
                mem_req_o  <= 1'b1;
                mem_addr_o <= base_i;
            end else if (next_i) begin
                // wraps mod 2^32 by design
                mem_req_o  <= 1'b1;
                mem_addr_o <= mem_addr_o + 32'd1;
            end else if (mem_req_o && mem_ack_i) begin
                mem_req_o <= 1'b0;
                word_o    <= mem_data_i;
                valid_o   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/lease_table_loader.sv
// Reloads lease policy config and tables from a memory image.
// Ports: start/base in, mem req/ack read port, con/llt write port,
// hold/busy status, done/error completion pulses.
module lease_table_loader
    import lease_table_loader_pkg::*;
(
    input  logic                     clock_i,
    input  logic                     resetn_i,
    input  logic                     start_i,
    input  logic [31:0]              base_addr_i,
    output logic                     mem_req_o,
    output logic [31:0]              mem_addr_o,
    input  logic                     mem_ack_i,
    input  logic [31:0]              mem_data_i,
    output logic                     con_wren_o,
    output logic                     llt_wren_o,
    output logic [BW_ADDR_SPACE-1:0] llt_addr_o,
    output logic [31:0]              llt_data_o,
    output logic                     hold_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o
);

    localparam logic [BW_ADDR_SPACE-1:0] TBL2 = BW_ADDR_SPACE'(N_ENTRIES);
    localparam logic [BW_CNT-1:0]        LAST = BW_CNT'(N_ENTRIES - 1);
    localparam logic [BW_CNT-1:0]        CLST = BW_CNT'(CON_DUAL_LEASE_REF);

    state_t            state_q, state_d;
    logic [BW_CNT-1:0] n_q, n_d;
    logic [BW_CNT-1:0] idx_q, idx_d;
    logic              half_q, half_d;
    logic              err_q, err_d;

    logic        f_load, f_next, f_valid;
    logic [31:0] f_word;

    logic                     con_we, llt_we;
    logic [BW_ADDR_SPACE-1:0] wr_addr;
    logic [31:0]              wr_data;

    lease_loader_fetch u_fetch (
        .clock_i    (clock_i),
        .resetn_i   (resetn_i),
        .load_i     (f_load),
        .next_i     (f_next),
        .base_i     (base_addr_i),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_ack_i  (mem_ack_i),
        .mem_data_i (mem_data_i),
        .word_o     (f_word),
        .valid_o    (f_valid)
    );

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            half_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            half_q  <= half_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        half_d  = half_q;
        err_d   = err_q;
        f_load  = 1'b0;
        f_next  = 1'b0;
        con_we  = 1'b0;
        llt_we  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    f_load  = 1'b1;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (f_valid) begin
                    if (f_word > 32'(N_ENTRIES)) begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        n_d     = f_word[BW_CNT-1:0];
                        f_next  = 1'b1;
                        state_d = ST_CFG;
                    end
                end
            end
            ST_CFG: begin
                if (f_valid) begin
                    con_we  = 1'b1;
                    wr_addr = idx_q;
                    wr_data = f_word;
                    if (idx_q == CLST) begin
                        idx_d  = '0;
                        half_d = 1'b0;
                        if (n_q == '0) begin
                            state_d = ST_CLEAR;
                        end else begin
                            f_next  = 1'b1;
                            state_d = ST_ADDR;
                        end
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        f_next = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (f_valid) begin
                    llt_we  = 1'b1;
                    wr_addr = idx_q;
                    wr_data = f_word;
                    f_next  = 1'b1;
                    if (idx_q == n_q - 1'b1) begin
                        idx_d   = '0;
                        state_d = ST_LEASE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_LEASE: begin
                if (f_valid) begin
                    llt_we  = 1'b1;
                    wr_addr = TBL2 + idx_q;
                    wr_data = f_word;
                    if (idx_q == n_q - 1'b1) begin
                        idx_d  = n_q;
                        half_d = 1'b0;
                        state_d = (n_q == BW_CNT'(N_ENTRIES))
                                ? ST_FIN : ST_CLEAR;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        f_next = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                // address table entry first, then its lease slot
                llt_we  = 1'b1;
                wr_addr = half_q ? (TBL2 + idx_q) : idx_q;
                half_d  = ~half_q;
                if (half_q) begin
                    if (idx_q == LAST) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign con_wren_o = con_we;
    assign llt_wren_o = llt_we;
    assign llt_addr_o = wr_addr;
    assign llt_data_o = wr_data;
    assign busy_o     = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign hold_o     = busy_o;
    assign done_o     = (state_q == ST_FIN);
    assign error_o    = (state_q == ST_FIN) && err_q;

endmodule
